// File: rtl/packet_router_arbiter_pkg.sv
// ============================================================================
// Module   : pkt_router_pkg
// Purpose  : Shared constants and types for the packet router front-end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pkt_router_pkg;

    localparam int PKT_W   = 20;
    localparam int HDR_LSB = 16;

    localparam logic [1:0] ERR_HDR     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/packet_router_arbiter_if.sv
// ============================================================================
// Module   : packet_router_arbiter_if
// Purpose  : Source-side request bus and router-side handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface packet_router_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PKT_W   = pkt_router_pkg::PKT_W
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*PKT_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rtr_packet_valid;
    logic [PKT_W-1:0]         rtr_data;
    logic                     rtr_busy;
    logic                     rtr_out_valid;
    logic [IDX_W-1:0]         grant_id;
    logic                     done;
    logic                     err;
    logic [1:0]               err_code;
    logic                     timeout_sticky;

    // Drives the sources and plays the router.
    modport master (
        output req_valid, req_data, rtr_busy, rtr_out_valid,
        input  req_ready, rtr_packet_valid, rtr_data, grant_id,
               done, err, err_code, timeout_sticky
    );

    modport slave (
        input  req_valid, req_data, rtr_busy, rtr_out_valid,
        output req_ready, rtr_packet_valid, rtr_data, grant_id,
               done, err, err_code, timeout_sticky
    );

endinterface

`default_nettype wire

// File: rtl/packet_router_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin winner search from a registered pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic               advance,
    input  wire logic [IDX_W-1:0]   next_ptr,
    output logic      [IDX_W-1:0]   winner,
    output logic                    any_req
);

    logic [IDX_W-1:0] r_ptr;
    int               w_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= next_ptr;
        end
    end

    // Scan farthest-first so the last hit is the one closest to the pointer.
    always_comb begin
        winner  = r_ptr;
        any_req = 1'b0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req[w_idx]) begin
                winner  = IDX_W'(w_idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/packet_router_arbiter.sv
// ============================================================================
// Module   : packet_router_arbiter
// Purpose  : Buffers one packet per source and feeds them one at a time to a
//            single-input packet router, with header filtering and timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module packet_router_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PKT_W   = pkt_router_pkg::PKT_W,
    parameter int TIMEOUT = 64
) (
    input wire logic              clk,
    input wire logic              rst,
    packet_router_arbiter_if.slave bus
);
    import pkt_router_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [NUM_REQ-1:0] r_full;
    logic [PKT_W-1:0]   r_buf [NUM_REQ];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_pkt_valid;
    logic [PKT_W-1:0]   r_data;
    logic [IDX_W-1:0]   r_grant;
    logic               r_done;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic               r_sticky;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any_req;
    logic               w_hdr_bad;
    logic               w_issue;
    logic               w_drop;
    logic               w_done;
    logic               w_tmo;
    logic               w_release;
    logic [IDX_W-1:0]   w_rel_idx;
    logic [IDX_W-1:0]   w_next_ptr;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (r_full),
        .advance  (w_release),
        .next_ptr (w_next_ptr),
        .winner   (w_winner),
        .any_req  (w_any_req)
    );

    // Any header bit above the two legal header bits marks the packet illegal.
    assign w_hdr_bad = (r_buf[w_winner] >> (HDR_LSB + 2)) != '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    if (w_hdr_bad) begin
                        w_drop = 1'b1;
                    end else if (!bus.rtr_busy) begin
                        w_issue     = 1'b1;
                        w_state_nxt = SEND;
                    end
                end
            end
            SEND: w_state_nxt = WAIT;
            WAIT: begin
                if (bus.rtr_out_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_release  = w_drop | w_done | w_tmo;
    assign w_rel_idx  = w_drop ? w_winner : r_grant;
    assign w_next_ptr = wrap_inc(w_rel_idx);

    // Release wins over accept; a released slot reads not-ready this cycle anyway.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_release && w_rel_idx == IDX_W'(i)) begin
                    r_full[i] <= 1'b0;
                end else if (bus.req_valid[i] && !r_full[i]) begin
                    r_full[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && !r_full[i]) begin
                r_buf[i] <= bus.req_data[i*PKT_W +: PKT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pkt_valid <= 1'b0;
            r_data      <= '0;
            r_grant     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pkt_valid <= w_issue;
            r_done      <= w_done;
            r_err       <= w_drop | w_tmo;
            r_err_code  <= w_drop ? ERR_HDR : (w_tmo ? ERR_TIMEOUT : 2'b00);
            if (w_tmo) begin
                r_sticky <= 1'b1;
            end
            if (w_issue) begin
                r_grant <= w_winner;
                r_data  <= r_buf[w_winner];
            end
            if (r_state == SEND) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready        = ~r_full;
    assign bus.rtr_packet_valid = r_pkt_valid;
    assign bus.rtr_data         = r_data;
    assign bus.grant_id         = r_grant;
    assign bus.done             = r_done;
    assign bus.err              = r_err;
    assign bus.err_code         = r_err_code;
    assign bus.timeout_sticky   = r_sticky;

endmodule

`default_nettype wire
